// File: rtl/operand_sequencer.sv
// operand_sequencer: run-control sequencer between the board switches/LEDs
// and the picoMIPS core. It synchronises and debounces the ready handshake,
// captures two operands on successive presses, launches the core with a
// one-cycle start pulse, watches for done with a timeout, and holds the
// result on the LEDs.
module operand_sequencer #(
  parameter int n          = 8,
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sw_ready,
  input  logic [n-1:0] sw_data,
  input  logic         core_done,
  input  logic [n-1:0] core_result,
  output logic         core_start,
  output logic [n-1:0] core_op1,
  output logic [n-1:0] core_op2,
  output logic [n-1:0] led,
  output logic         busy,
  output logic         err
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] X_WAIT = 3'd0;
  localparam logic [2:0] X_REL  = 3'd1;
  localparam logic [2:0] Y_WAIT = 3'd2;
  localparam logic [2:0] Y_REL  = 3'd3;
  localparam logic [2:0] START  = 3'd4;
  localparam logic [2:0] RUN    = 3'd5;

  // two-flop synchronizer stages; _p1 is the synchronized value
  logic         rdy_p0, rdy_p1;
  logic [n-1:0] data_p0, data_p1;

  logic          deb_ready;
  logic          deb_q;
  logic [DW-1:0] deb_cnt;
  logic          rise, fall;

  logic [2:0]    state;
  logic [TW-1:0] tmo_cnt;
  // set once a result (or error) is on the LEDs, so X_WAIT keeps showing it
  logic          hold;

  // Bring the raw switches into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_p0  <= 1'b0;
      rdy_p1  <= 1'b0;
      data_p0 <= '0;
      data_p1 <= '0;
    end else begin
      rdy_p0  <= sw_ready;
      rdy_p1  <= rdy_p0;
      data_p0 <= sw_data;
      data_p1 <= data_p0;
    end
  end

  // Debounce: the synchronized ready must disagree for DEB_CYCLES samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_ready <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      deb_q <= deb_ready;
      if (rdy_p1 == deb_ready) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_ready <= ~deb_ready;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign rise = deb_ready & ~deb_q;
  assign fall = ~deb_ready & deb_q;

  // Run-control FSM: capture x, capture y, launch, then wait for done or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= X_WAIT;
      tmo_cnt  <= '0;
      hold     <= 1'b0;
      core_op1 <= '0;
      core_op2 <= '0;
      led      <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        X_WAIT: begin
          if (rise) begin
            core_op1 <= data_p1;
            err      <= 1'b0;
            hold     <= 1'b0;
            led      <= data_p1;
            state    <= X_REL;
          end else if (!hold) begin
            led <= data_p1;
          end
        end
        X_REL: begin
          led <= data_p1;
          if (fall) state <= Y_WAIT;
        end
        Y_WAIT: begin
          led <= data_p1;
          if (rise) begin
            core_op2 <= data_p1;
            state    <= Y_REL;
          end
        end
        Y_REL: begin
          led <= data_p1;
          if (fall) state <= START;
        end
        START: begin
          tmo_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          if (core_done) begin
            led   <= core_result;
            hold  <= 1'b1;
            state <= X_WAIT;
          end else if (tmo_cnt == TMO_LAST) begin
            led   <= '1;
            err   <= 1'b1;
            hold  <= 1'b1;
            state <= X_WAIT;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= X_WAIT;
      endcase
    end
  end

  assign core_start = (state == START);
  assign busy       = (state == START) || (state == RUN);

endmodule

// File: tb/tb_operand_sequencer.sv
// Testbench for operand_sequencer: directed scenarios with literal
// expectations plus a randomized phase, all outputs compared every cycle
// against a behavioural model of the sequencer.
module tb_operand_sequencer;

  localparam int N   = 8;
  localparam int DEB = 4;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sw_ready;
  logic [N-1:0] sw_data;
  logic         core_done;
  logic [N-1:0] core_result;
  logic         core_start;
  logic [N-1:0] core_op1, core_op2, led;
  logic         busy, err;

  int checks = 0;
  int passed = 0;
  int starts = 0;

  // core responder controls
  int           resp_j   = -1;
  logic [N-1:0] resp_val = 8'h00;
  int           pend     = 0;
  bit           inj      = 1'b0;
  bit           spur_en  = 1'b0;

  operand_sequencer #(.n(N), .DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .sw_ready(sw_ready), .sw_data(sw_data),
    .core_done(core_done), .core_result(core_result), .core_start(core_start),
    .core_op1(core_op1), .core_op2(core_op2), .led(led), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // phases: 0 wait x, 1 release x, 2 wait y, 3 release y, 4 start, 5 run
  bit           m_r1 = 0, m_r2 = 0;
  logic [N-1:0] m_d1 = 0, m_d2 = 0;
  bit           m_win[$];
  bit           m_deb = 0, m_debq = 0;
  int           m_phase = 0;
  int           m_run = 0;
  bit           m_hold = 0;
  logic [N-1:0] m_op1 = 0, m_op2 = 0, m_led = 0;
  bit           m_err = 0;

  task automatic model_reset();
    m_r1 = 0; m_r2 = 0; m_d1 = 0; m_d2 = 0;
    m_win.delete();
    m_deb = 0; m_debq = 0; m_phase = 0; m_run = 0; m_hold = 0;
    m_op1 = 0; m_op2 = 0; m_led = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit s, rise, fall, new_deb, all_diff;
    logic [N-1:0] sd;
    s = m_r2; sd = m_d2;
    rise = m_deb && !m_debq;
    fall = !m_deb && m_debq;
    // debounced level flips once the last DEB synchronized samples all disagree with it
    m_win.push_back(s);
    if (m_win.size() > DEB) void'(m_win.pop_front());
    new_deb = m_deb;
    all_diff = (m_win.size() == DEB);
    foreach (m_win[i]) if (m_win[i] == m_deb) all_diff = 0;
    if (all_diff) begin new_deb = !m_deb; m_win.delete(); end
    case (m_phase)
      0: begin
        if (!m_hold) m_led = sd;
        if (rise) begin m_op1 = sd; m_err = 0; m_hold = 0; m_led = sd; m_phase = 1; end
      end
      1: begin m_led = sd; if (fall) m_phase = 2; end
      2: begin m_led = sd; if (rise) begin m_op2 = sd; m_phase = 3; end end
      3: begin m_led = sd; if (fall) m_phase = 4; end
      4: begin m_run = 0; m_phase = 5; end
      default: begin
        if (core_done) begin m_led = core_result; m_hold = 1; m_phase = 0; end
        else if (m_run == TMO - 1) begin m_led = 8'hFF; m_err = 1; m_hold = 1; m_phase = 0; end
        else m_run++;
      end
    endcase
    m_r2 = m_r1; m_r1 = sw_ready;
    m_d2 = m_d1; m_d1 = sw_data;
    m_debq = m_deb; m_deb = new_deb;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("core_start", core_start, (m_phase == 4));
    chk("busy", busy, (m_phase == 4 || m_phase == 5));
    chk("core_op1", core_op1, m_op1);
    chk("core_op2", core_op2, m_op2);
    chk("led", led, m_led);
    chk("err", err, m_err);
    if (core_start) starts++;
  end

  // core stand-in: answers start after resp_j RUN cycles, plus optional injections
  initial begin
    core_done = 1'b0; core_result = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin core_done = 1'b1; core_result = resp_val; end
      end else if (core_start && resp_j >= 0) pend = resp_j + 1;
      if (inj) begin core_done = 1'b1; core_result = 8'hEE; inj = 1'b0; end
      if (spur_en && $urandom_range(0, 11) == 0) begin
        core_done = 1'b1; core_result = 8'($urandom);
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press(input logic [N-1:0] d, input int tail);
    sw_data = d; cyc(3);
    sw_ready = 1'b1; cyc(10);
    sw_ready = 1'b0; cyc(tail);
  endtask

  task automatic wait_start();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_start) begin ok = 1; break; end
    end
    chk("start_seen", ok, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st0, lat;
    bit seen;
    rst_n = 1'b0; sw_ready = 1'b0; sw_data = '0;
    cyc(3);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    cyc(2);

    // nominal sequence
    st0 = starts;
    resp_j = 2; resp_val = 8'h5A;
    press(8'h12, 10);
    press(8'h34, 0);
    cyc(30);
    chk("nom_op1", core_op1, 8'h12);
    chk("nom_op2", core_op2, 8'h34);
    chk("nom_led", led, 8'h5A);
    chk("nom_busy", busy, 0);
    chk("nom_starts", starts - st0, 1);

    // 3-cycle glitch is ignored
    seen = 0;
    sw_ready = 1'b1; cyc(3); sw_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(1); if (dut.deb_ready) seen = 1; end
    chk("glitch_deb", seen, 0);
    chk("glitch_op1", core_op1, 8'h12);
    chk("glitch_led", led, 8'h5A);

    // clean press: debounced ready rises 6 clocks after the raw edge
    sw_data = 8'h77; cyc(3);
    sw_ready = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (dut.deb_ready) begin lat = i; break; end
    end
    chk("deb_latency", lat, 6);
    cyc(4);
    chk("clean_op1", core_op1, 8'h77);
    sw_ready = 1'b0; cyc(10);

    // timeout
    resp_j = -1;
    press(8'h56, 0);
    wait_start();
    cyc(16);
    chk("tmo_busy_last", busy, 1);
    chk("tmo_err_early", err, 0);
    cyc(1);
    chk("tmo_led", led, 8'hFF);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    sw_data = 8'h99; cyc(5);
    chk("tmo_hold", led, 8'hFF);
    press(8'h21, 10);
    chk("err_clear", err, 0);
    chk("op1_after_tmo", core_op1, 8'h21);

    // done while waiting for y is ignored
    inj = 1'b1; cyc(3);
    chk("ydone_busy", busy, 0);
    chk("ydone_led", led, 8'h21);

    // done on the timeout cycle wins
    resp_j = 15; resp_val = 8'hA5;
    press(8'h43, 0);
    wait_start();
    cyc(17);
    chk("edge_led", led, 8'hA5);
    chk("edge_err", err, 0);
    chk("edge_busy", busy, 0);

    // presses during RUN are discarded
    resp_j = -1;
    st0 = starts;
    press(8'h01, 10);
    press(8'h02, 0);
    wait_start();
    sw_data = 8'hCC;
    sw_ready = 1'b1; cyc(4); sw_ready = 1'b0; cyc(4);
    sw_ready = 1'b1; cyc(4); sw_ready = 1'b0; cyc(20);
    chk("run_op1", core_op1, 8'h01);
    chk("run_op2", core_op2, 8'h02);
    chk("run_starts", starts - st0, 1);
    chk("run_err", err, 1);

    // asynchronous reset mid-RUN
    press(8'h0A, 10);
    press(8'h0B, 0);
    wait_start();
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", core_start, 0);
    chk("arst_op1", core_op1, 0);
    chk("arst_op2", core_op2, 0);
    chk("arst_led", led, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    cyc(2); rst_n = 1'b1; cyc(2);
    resp_j = 4; resp_val = 8'h3C;
    press(8'h44, 10);
    press(8'h55, 0);
    cyc(30);
    chk("post_op1", core_op1, 8'h44);
    chk("post_op2", core_op2, 8'h55);
    chk("post_led", led, 8'h3C);

    // randomized phase, checked every cycle against the model
    spur_en = 1'b1;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin sw_data = 8'($urandom); cyc($urandom_range(1, 3)); end
        3, 4, 5, 6: begin sw_ready = ~sw_ready; cyc($urandom_range(1, 12)); end
        7: begin
          resp_j = int'($urandom_range(0, 21)) - 1;
          resp_val = 8'($urandom);
          cyc(1);
        end
        8: cyc($urandom_range(1, 20));
        default: begin
          if ($urandom_range(0, 7) == 0) begin
            #2 rst_n = 1'b0;
            cyc(2); rst_n = 1'b1;
          end
          cyc(1);
        end
      endcase
    end
    spur_en = 1'b0;
    cyc(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
